// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one multi-cycle memory port between fetch (IF) and load/store (DM)
// Optional ARB_ROUND_ROBIN_EN: alternate the winner on simultaneous requests instead of DM-first.
module mem_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_funct3,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

    state_t            state;
    logic [2:0]        cnt;
    logic              owner_dm;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              pick_dm;
    logic              accept;

    // The ack cycle is spent in IDLE without sampling: the requester still holds req then.
    assign accept = (state == IDLE) && (if_req || dm_req) && !(if_ack || dm_ack);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_dm;

    always_comb begin
        pick_dm = (if_req && dm_req) ? ~last_dm : dm_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_dm <= 1'b0;
        end else if (accept) begin
            last_dm <= pick_dm;
        end
    end
`else
    always_comb begin
        pick_dm = dm_req;
    end
`endif

    assign mem_en     = ((state == ISSUE) || (state == WAIT)) && !rst;
    assign mem_we     = (state == ISSUE) && we_q && !rst;
    assign mem_funct3 = funct3_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            owner_dm <= 1'b0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            grant    <= 2'b00;
            if_ack   <= 1'b0;
            dm_ack   <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            if_ack <= 1'b0;
            dm_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner_dm <= pick_dm;
                        grant    <= pick_dm ? 2'b10 : 2'b01;
                        addr_q   <= pick_dm ? dm_addr : if_addr;
                        we_q     <= pick_dm && dm_we;
                        funct3_q <= pick_dm ? dm_funct3 : 3'b010;
                        wdata_q  <= pick_dm ? dm_wdata : '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt <= CNT_INIT;
                    if (LAT == 1) begin
                        rdata_q <= mem_rdata;
                        state   <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        rdata_q <= mem_rdata;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (owner_dm) begin
                        dm_ack   <= 1'b1;
                        dm_rdata <= rdata_q;
                    end else begin
                        if_ack   <= 1'b1;
                        if_rdata <= rdata_q;
                    end
                    grant <= 2'b00;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a behavioural memory
module tb_mem_port_arbiter;
    parameter int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_ack;
    logic [7:0]  if_addr;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we, dm_ack;
    logic [2:0]  dm_funct3;
    logic [7:0]  dm_addr;
    logic [31:0] dm_wdata, dm_rdata;
    logic        mem_en, mem_we;
    logic [2:0]  mem_funct3;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        busy;
    logic [1:0]  grant;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_funct3(dm_funct3), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_dm;
        bit          is_load;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          we_cnt = 0;
    logic        preload = 1'b1;
    logic [31:0] mem [0:63];
    logic [31:0] shadow [0:63];

    function automatic logic [31:0] init_word(int i);
        return (i == 4) ? 32'hDEADBEEF : (32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory: reads are combinational on the held address, writes land on the clock edge.
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preload) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mem_we) we_cnt++;
        if (!rst && (if_ack || dm_ack)) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'd0, if_ack, dm_ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_port", {30'd0, if_ack, dm_ack}, e.is_dm ? 32'd1 : 32'd2);
                if (e.is_load) check("rdata", e.is_dm ? dm_rdata : if_rdata, e.data);
                check("ack_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic push(input bit is_dm, input bit is_load, input logic [31:0] d, input int c);
        exp_t e;
        e.is_dm = is_dm; e.is_load = is_load; e.data = d; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic drive_if(input logic [7:0] a);
        if_req = 1'b1; if_addr = a;
    endtask

    task automatic drive_dm(input bit we, input logic [7:0] a, input logic [31:0] d);
        dm_req = 1'b1; dm_we = we; dm_funct3 = 3'b010; dm_addr = a; dm_wdata = d;
        if (we) shadow[a[7:2]] = d;
    endtask

    // Waits for n acks, dropping each acked request in the cycle after its ack.
    task automatic wait_acks(input int n);
        int got = 0;
        bit a_if, a_dm;
        for (int i = 0; i < 80 && got < n; i++) begin
            @(negedge clk);
            if (if_ack || dm_ack) begin
                a_if = if_ack; a_dm = dm_ack;
                got++;
                @(posedge clk); #1;
                if (a_if) if_req = 1'b0;
                if (a_dm) begin dm_req = 1'b0; dm_we = 1'b0; end
            end
        end
        if (got < n) check("ack_timeout", got, n);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
        dm_funct3 = 0; dm_addr = 0; dm_wdata = 0;
        for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
        step(3);
        preload = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_acks", {if_ack, dm_ack}, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        check("rst_mem_en", mem_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(1);

        // T1: single fetch, grant held over ISSUE..RESP
        drive_if(8'h10);
        push(0, 1, 32'hDEADBEEF, cyc + LAT + 2);
        @(negedge clk);
        check("t1_grant_c0", grant, 0);
        for (int i = 1; i <= LAT + 1; i++) begin
            @(negedge clk);
            check("t1_grant", grant, 2'b01);
            if (i == 1) check("t1_mem_addr", mem_addr, 8'h10);
        end
        wait_acks(1);

        // T2: store then fetch the same word
        we_cnt = 0;
        drive_dm(1, 8'h20, 32'h12345678);
        push(1, 0, 32'h0, cyc + LAT + 2);
        wait_acks(1);
        check("t2_we_pulses", we_cnt, 1);
        check("t2_mem_word", mem[8], 32'h12345678);
        drive_if(8'h20);
        push(0, 1, 32'h12345678, cyc + LAT + 2);
        wait_acks(1);

        // T3: simultaneous requests; DM wins from IF-last pointer or fixed priority
        drive_if(8'h10);
        drive_dm(0, 8'h20, 32'h0);
        push(1, 1, shadow[8], cyc + LAT + 2);
        push(0, 1, 32'hDEADBEEF, cyc + 2 * LAT + 5);
        wait_acks(2);
`ifdef ARB_ROUND_ROBIN_EN
        drive_dm(0, 8'h04, 32'h0);
        push(1, 1, shadow[1], cyc + LAT + 2);
        wait_acks(1);
        drive_if(8'h08);
        drive_dm(0, 8'h0c, 32'h0);
        push(0, 1, shadow[2], cyc + LAT + 2);
        push(1, 1, shadow[3], cyc + 2 * LAT + 5);
        wait_acks(2);
`endif

        // T4: fetch dropped early still completes exactly once
        drive_if(8'h14);
        push(0, 1, shadow[5], cyc + LAT + 2);
        step(2);
        if_req = 1'b0;
        wait_acks(1);
        step(8);
        check("t4_no_extra", sb.size(), 0);

        // T5: reset during ISSUE of a store discards it
        we_cnt = 0;
        dm_req = 1'b1; dm_we = 1'b1; dm_funct3 = 3'b010; dm_addr = 8'h30; dm_wdata = 32'h5555_AAAA;
        step(1);
        rst = 1'b1; dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        check("t5_mem_we", mem_we, 0);
        step(1);
        @(negedge clk);
        check("t5_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        step(6);
        check("t5_we_pulses", we_cnt, 0);
        check("t5_mem_word", mem[12], shadow[12]);

        // T6: random mixed traffic from idle
        for (int n = 0; n < 20; n++) begin
            int kind;
            logic [7:0] a;
            logic [31:0] d;
            kind = $urandom_range(0, 2);
            a = 8'($urandom_range(0, 15)) << 2;
            d = $urandom;
            if (kind == 0) begin
                drive_if(a);
                push(0, 1, shadow[a[7:2]], cyc + LAT + 2);
            end else if (kind == 1) begin
                push(1, 1, shadow[a[7:2]], cyc + LAT + 2);
                drive_dm(0, a, d);
            end else begin
                drive_dm(1, a, d);
                push(1, 0, 32'h0, cyc + LAT + 2);
            end
            wait_acks(1);
            step($urandom_range(0, 2));
        end
        step(4);
        check("t6_all_acked", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
